// File: rtl/cpu_pkg.sv
// Shared definitions for the PC sequencer: state encoding, trap causes and default vectors.
package cpu_pkg;

    typedef enum logic [2:0] {
        StBoot   = 3'd0,
        StFetch  = 3'd1,
        StExec   = 3'd2,
        StUpdate = 3'd3,
        StTrap   = 3'd4
    } pcs_state_t;

    localparam logic [1:0] CauseNone       = 2'd0;
    localparam logic [1:0] CauseFetchErr   = 2'd1;
    localparam logic [1:0] CauseTimeout    = 2'd2;
    localparam logic [1:0] CauseMisaligned = 2'd3;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC source selection (jump > taken branch > sequential) with word-alignment check.
module pc_next_mux (
    input  logic        jmp_i,
    input  logic [31:0] jmp_target_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic [31:0] pc_cur_i,
    output logic [31:0] target_o,
    output logic        misaligned_o
);

    always_comb begin
        if (jmp_i) begin
            target_o = jmp_target_i;
        end else if (br_taken_i) begin
            target_o = br_target_i;
        end else begin
            target_o = pc_cur_i + 32'd4;
        end
        misaligned_o = (target_o[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle controller owning all PC register writes: boot, fetch, execute, update, trap.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] pc_cur,
    output logic        pc_write,
    output logic [31:0] pc_next,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic        fetch_err,
    input  logic        instr_done,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        stall,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [7:0]  trap_cnt
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    pcs_state_t  state_q;
    logic [7:0]  wait_q;
    logic [31:0] target_q;
    logic        misal_q;
    logic [1:0]  cause_q;
    logic [7:0]  trap_cnt_q;

    logic [31:0] mux_target;
    logic        mux_misal;

    pc_next_mux u_next_mux (
        .jmp_i        (jmp),
        .jmp_target_i (jmp_target),
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .pc_cur_i     (pc_cur),
        .target_o     (mux_target),
        .misaligned_o (mux_misal)
    );

    // Cause and count are updated on entry to TRAP so they are visible with the trap pulse.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= StBoot;
            wait_q     <= 8'd0;
            target_q   <= 32'd0;
            misal_q    <= 1'b0;
            cause_q    <= CauseNone;
            trap_cnt_q <= 8'd0;
        end else begin
            unique case (state_q)
                StBoot: state_q <= StFetch;
                StFetch: begin
                    if (fetch_err) begin
                        state_q    <= StTrap;
                        cause_q    <= CauseFetchErr;
                        trap_cnt_q <= sat_inc8(trap_cnt_q);
                        wait_q     <= 8'd0;
                    end else if (fetch_ack) begin
                        state_q <= StExec;
                        wait_q  <= 8'd0;
                    end else if (wait_q == TimeoutLast) begin
                        state_q    <= StTrap;
                        cause_q    <= CauseTimeout;
                        trap_cnt_q <= sat_inc8(trap_cnt_q);
                        wait_q     <= 8'd0;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StExec: begin
                    if (instr_done && !stall) begin
                        target_q <= mux_target;
                        misal_q  <= mux_misal;
                        state_q  <= StUpdate;
                    end
                end
                StUpdate: begin
                    if (!stall) begin
                        if (misal_q) begin
                            state_q    <= StTrap;
                            cause_q    <= CauseMisaligned;
                            trap_cnt_q <= sat_inc8(trap_cnt_q);
                        end else begin
                            state_q <= StFetch;
                        end
                    end
                end
                StTrap: state_q <= StFetch;
                default: state_q <= StBoot;
            endcase
        end
    end

    // Gating on Reset keeps the BOOT decode from pulsing while reset is still held.
    always_comb begin
        pc_write   = 1'b0;
        pc_next    = 32'd0;
        fetch_req  = 1'b0;
        trap       = 1'b0;
        fetch_addr = pc_cur;
        trap_cause = cause_q;
        trap_cnt   = trap_cnt_q;
        if (!Reset) begin
            case (state_q)
                StBoot: begin
                    pc_write = 1'b1;
                    pc_next  = RESET_VECTOR;
                end
                StFetch: fetch_req = 1'b1;
                StUpdate: begin
                    if (!stall && !misal_q) begin
                        pc_write = 1'b1;
                        pc_next  = target_q;
                    end
                end
                StTrap: begin
                    pc_write = 1'b1;
                    pc_next  = EXC_VECTOR;
                    trap     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] pc_cur;
    logic        pc_write;
    logic [31:0] pc_next;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic        fetch_err;
    logic        instr_done;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic        stall;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [7:0]  trap_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pc_sequencer dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .pc_cur     (pc_cur),
        .pc_write   (pc_write),
        .pc_next    (pc_next),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .fetch_err  (fetch_err),
        .instr_done (instr_done),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .stall      (stall),
        .trap       (trap),
        .trap_cause (trap_cause),
        .trap_cnt   (trap_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow after a further #1.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset = 1'b0; pc_cur = 32'd0; fetch_ack = 1'b0; fetch_err = 1'b0;
        instr_done = 1'b0; jmp = 1'b0; jmp_target = 32'd0; br_taken = 1'b0;
        br_target = 32'd0; stall = 1'b0;
        #1 Reset = 1'b1;
        #1;
        chk("rst_pc_write", pc_write, 1'b0);
        chk("rst_fetch_req", fetch_req, 1'b0);
        chk("rst_trap", trap, 1'b0);
        chk("rst_cause", trap_cause, 2'd0);
        chk("rst_cnt", trap_cnt, 8'd0);
        chk("rst_pc_next", pc_next, 32'd0);

        tick(); tick();
        Reset = 1'b0; #1;
        chk("boot_pc_write", pc_write, 1'b1);
        chk("boot_pc_next", pc_next, 32'h0);
        chk("boot_fetch_req", fetch_req, 1'b0);

        tick(); #1;
        chk("f1_fetch_req", fetch_req, 1'b1);
        chk("f1_fetch_addr", fetch_addr, 32'h0);
        chk("f1_pc_write", pc_write, 1'b0);
        tick(); fetch_ack = 1'b1; #1;
        chk("f2_fetch_req", fetch_req, 1'b1);
        tick(); fetch_ack = 1'b0; instr_done = 1'b1; #1;
        chk("exec_fetch_req", fetch_req, 1'b0);
        chk("exec_pc_write", pc_write, 1'b0);
        tick(); instr_done = 1'b0; #1;
        chk("seq_pc_write", pc_write, 1'b1);
        chk("seq_pc_next", pc_next, 32'h4);

        // Jump and branch together: jump wins
        tick(); pc_cur = 32'h4; fetch_ack = 1'b1; #1;
        chk("f_addr4", fetch_addr, 32'h4);
        tick(); fetch_ack = 1'b0; instr_done = 1'b1; jmp = 1'b1; jmp_target = 32'h100;
        br_taken = 1'b1; br_target = 32'h200; #1;
        tick(); instr_done = 1'b0; jmp = 1'b0; br_taken = 1'b0; #1;
        chk("prio_pc_write", pc_write, 1'b1);
        chk("prio_pc_next", pc_next, 32'h100);

        // instr_done under stall is ignored; then stall held 3 cycles in UPDATE
        tick(); pc_cur = 32'h100; fetch_ack = 1'b1; #1;
        tick(); fetch_ack = 1'b0; instr_done = 1'b1; stall = 1'b1; #1;
        chk("exec_stall_pc_write", pc_write, 1'b0);
        tick(); stall = 1'b0; br_taken = 1'b1; br_target = 32'h40; #1;
        chk("exec_held_pc_write", pc_write, 1'b0);
        chk("exec_held_fetch_req", fetch_req, 1'b0);
        tick(); instr_done = 1'b0; br_taken = 1'b0; stall = 1'b1; jmp = 1'b1;
        jmp_target = 32'h300; #1;
        chk("stall1_pc_write", pc_write, 1'b0);
        tick(); #1;
        chk("stall2_pc_write", pc_write, 1'b0);
        tick(); #1;
        chk("stall3_pc_write", pc_write, 1'b0);
        tick(); stall = 1'b0; jmp = 1'b0; #1;
        chk("unstall_pc_write", pc_write, 1'b1);
        chk("unstall_pc_next", pc_next, 32'h40);

        // Fetch timeout: 15 FETCH cycles without ack
        tick(); pc_cur = 32'h40; #1;
        chk("to_c1_fetch_req", fetch_req, 1'b1);
        repeat (14) tick();
        #1;
        chk("to_c15_fetch_req", fetch_req, 1'b1);
        chk("to_c15_trap", trap, 1'b0);
        tick(); #1;
        chk("to_trap", trap, 1'b1);
        chk("to_pc_write", pc_write, 1'b1);
        chk("to_pc_next", pc_next, 32'h80);
        chk("to_cause", trap_cause, 2'd2);
        chk("to_cnt", trap_cnt, 8'd1);

        // err beats ack
        tick(); pc_cur = 32'h80; #1;
        chk("post_trap_trap", trap, 1'b0);
        chk("cause_held", trap_cause, 2'd2);
        fetch_err = 1'b1; fetch_ack = 1'b1;
        tick(); fetch_err = 1'b0; fetch_ack = 1'b0; #1;
        chk("err_trap", trap, 1'b1);
        chk("err_cause", trap_cause, 2'd1);
        chk("err_cnt", trap_cnt, 8'd2);

        // Misaligned branch target
        tick(); fetch_ack = 1'b1; #1;
        tick(); fetch_ack = 1'b0; instr_done = 1'b1; br_taken = 1'b1; br_target = 32'h102; #1;
        tick(); instr_done = 1'b0; br_taken = 1'b0; #1;
        chk("mis_upd_pc_write", pc_write, 1'b0);
        chk("mis_upd_trap", trap, 1'b0);
        tick(); #1;
        chk("mis_trap", trap, 1'b1);
        chk("mis_pc_next", pc_next, 32'h80);
        chk("mis_cause", trap_cause, 2'd3);
        chk("mis_cnt", trap_cnt, 8'd3);

        // Sequential wrap
        tick(); pc_cur = 32'hFFFF_FFFC; fetch_ack = 1'b1; #1;
        tick(); fetch_ack = 1'b0; instr_done = 1'b1; #1;
        tick(); instr_done = 1'b0; #1;
        chk("wrap_pc_write", pc_write, 1'b1);
        chk("wrap_pc_next", pc_next, 32'h0);
        chk("wrap_trap", trap, 1'b0);

        // Drive the trap count to 256 traps total
        tick(); pc_cur = 32'h0; #1;
        for (int i = 0; i < 253; i++) begin
            fetch_err = 1'b1;
            tick();
            fetch_err = 1'b0;
            tick();
        end
        #1;
        chk("sat_cnt", trap_cnt, 8'd255);
        chk("sat_fetch_req", fetch_req, 1'b1);
        fetch_err = 1'b1;
        tick(); fetch_err = 1'b0; #1;
        chk("sat_trap", trap, 1'b1);
        chk("sat_cnt_hold", trap_cnt, 8'd255);
        tick(); #1;
        chk("pre_rst_fetch_req", fetch_req, 1'b1);

        // Asynchronous reset mid-FETCH
        Reset = 1'b1; #1;
        chk("arst_fetch_req", fetch_req, 1'b0);
        chk("arst_pc_write", pc_write, 1'b0);
        chk("arst_cnt", trap_cnt, 8'd0);
        chk("arst_cause", trap_cause, 2'd0);
        tick(); Reset = 1'b0; #1;
        chk("reboot_pc_write", pc_write, 1'b1);
        chk("reboot_pc_next", pc_next, 32'h0);
        tick(); #1;
        chk("reboot_fetch_req", fetch_req, 1'b1);
        chk("reboot_fetch_pc_write", pc_write, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
